// File: rtl/cc_driver_input_conditioner.sv
// rtl/cc_driver_input_conditioner.sv - sync, debounce and pulse shaping of raw cruise-control driver inputs
// Brake dominates all commands; accel/coast auto-repeat; cancel > set > resume.
module cc_driver_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 4,
    parameter int CNT_W           = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic throttle_raw,
    input  logic brake_raw,
    input  logic set_raw,
    input  logic resume_raw,
    input  logic cancel_raw,
    input  logic accel_raw,
    input  logic coast_raw,
    output logic throttle,
    output logic brake,
    output logic set,
    output logic resume,
    output logic cancel,
    output logic accel,
    output logic coast,
    output logic input_fault
);

    localparam int N_IN  = 7;
    localparam int I_THR = 0;
    localparam int I_BRK = 1;
    localparam int I_SET = 2;
    localparam int I_RES = 3;
    localparam int I_CAN = 4;
    localparam int I_ACC = 5;
    localparam int I_COA = 6;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] DB_LIM   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] RPT_DLY  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RPT_RATE = CNT_W'(REPEAT_RATE);

    typedef enum logic [1:0] {RELEASED, WAIT, REPEAT, BLOCKED} rep_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic [N_IN-1:0] raw, sync1_q, sync2_q, deb_q, deb_d;
    logic [2:0]      cmd_prev_q;
    logic [1:0]      rep_pulse;
    logic [7:0]      out_q, out_d;
    logic            brake_lvl, rise_set, rise_res, rise_can, cancel_pulse;

    assign raw = {coast_raw, accel_raw, cancel_raw, resume_raw, set_raw, brake_raw, throttle_raw};

    for (genvar g = 0; g < N_IN; g++) begin : g_deb
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             deb_nxt;

        // Any mismatch run shorter than the limit falls back to zero when sync agrees again.
        always_comb begin
            cnt_d   = '0;
            deb_nxt = deb_q[g];
            if (sync2_q[g] != deb_q[g]) begin
                cnt_d = sat_inc(cnt_q);
                if (cnt_d >= DB_LIM) begin
                    deb_nxt = sync2_q[g];
                    cnt_d   = '0;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign deb_d[g] = deb_nxt;
    end

    for (genvar g = 0; g < 2; g++) begin : g_rep
        rep_state_e       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pulse;

        always_comb begin
            state_d = state_q;
            cnt_d   = sat_inc(cnt_q);
            pulse   = 1'b0;
            if (!deb_q[I_ACC+g]) begin
                state_d = RELEASED;
                cnt_d   = '0;
            end else if (deb_q[I_ACC] && deb_q[I_COA]) begin
                state_d = BLOCKED;
                cnt_d   = '0;
            end else begin
                unique case (state_q)
                    RELEASED: begin
                        state_d = WAIT;
                        cnt_d   = '0;
                        pulse   = 1'b1;
                    end
                    WAIT: begin
                        if (cnt_d >= RPT_DLY) begin
                            state_d = REPEAT;
                            cnt_d   = '0;
                            pulse   = 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (cnt_d >= RPT_RATE) begin
                            cnt_d = '0;
                            pulse = 1'b1;
                        end
                    end
                    BLOCKED: cnt_d = '0;
                    default: state_d = RELEASED;
                endcase
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                state_q <= RELEASED;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign rep_pulse[g] = pulse;
    end

    assign brake_lvl    = deb_q[I_BRK];
    assign rise_set     = deb_q[I_SET] & ~cmd_prev_q[0];
    assign rise_res     = deb_q[I_RES] & ~cmd_prev_q[1];
    assign rise_can     = deb_q[I_CAN] & ~cmd_prev_q[2];
    assign cancel_pulse = rise_can & ~brake_lvl;

    always_comb begin
        out_d    = '0;
        out_d[0] = deb_q[I_THR] & ~brake_lvl;
        out_d[1] = brake_lvl;
        out_d[2] = rise_set & ~rise_can & ~brake_lvl;
        out_d[3] = rise_res & ~rise_set & ~rise_can & ~brake_lvl;
        out_d[4] = cancel_pulse;
        out_d[5] = rep_pulse[0] & ~cancel_pulse & ~brake_lvl;
        out_d[6] = rep_pulse[1] & ~cancel_pulse & ~brake_lvl;
        out_d[7] = (deb_q[I_ACC] & deb_q[I_COA]) | (deb_q[I_SET] & deb_q[I_RES]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            cmd_prev_q <= '0;
            out_q      <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            cmd_prev_q <= {deb_q[I_CAN], deb_q[I_RES], deb_q[I_SET]};
            out_q      <= out_d;
        end
    end

    assign throttle    = out_q[0];
    assign brake       = out_q[1];
    assign set         = out_q[2];
    assign resume      = out_q[3];
    assign cancel      = out_q[4];
    assign accel       = out_q[5];
    assign coast       = out_q[6];
    assign input_fault = out_q[7];

endmodule
